// File: rtl/acc_requant_writeback.sv
// acc_requant_writeback: requantises accumulator tiles, packs PACK tiles per line, writes lines
// to the result SRAM at a wrapping address. Macro REQUANT_RELU_EN selects ReLU output.
module acc_requant_writeback #(
   parameter int TILE_SIZE  = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int PACK       = 4,
   parameter int ADDR_W     = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 s_axis_TVALID,
   output logic                                 s_axis_TREADY,
   input  logic [TILE_SIZE*ACC_WIDTH-1:0]       reduced_vec,
   output logic                                 wr_en,
   input  logic                                 wr_ready,
   output logic [ADDR_W-1:0]                    wr_addr,
   output logic [PACK*TILE_SIZE*DATA_WIDTH-1:0] wr_data,
   output logic                                 done,
   output logic [15:0]                          sat_cnt
);
   localparam int VEC_W  = TILE_SIZE*DATA_WIDTH;
   localparam int LINE_W = PACK*VEC_W;
   localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam logic FILL = 1'b0;
   localparam logic HOLD = 1'b1;
   localparam logic signed [ACC_WIDTH:0] RND  = (ACC_WIDTH+1)'(1 << (FRAC_BITS-1));
   localparam logic signed [ACC_WIDTH:0] MAXV = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

   logic [VEC_W-1:0]  q_vec_q, q_vec_d, req_vec;
   logic              q_valid_q, q_valid_d;
   logic              state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [LINE_W-1:0] wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic [15:0]       sat_cnt_q, sat_cnt_d, n_sat;
   logic [16:0]       sat_sum;
   logic [TILE_SIZE-1:0] sat_flag;
   logic              accept, q_adv, wr_hs;

   // start freezes the register stage for one cycle so a held vector carries into the new frame
   assign q_adv         = q_valid_q && (state_q == FILL || wr_ready) && !start;
   assign s_axis_TREADY = !rst && (!q_valid_q || q_adv);
   assign accept        = s_axis_TVALID && s_axis_TREADY;
   assign wr_hs         = (state_q == HOLD) && wr_ready && !start;

   for (genvar i = 0; i < TILE_SIZE; i++) begin : g_lane
      logic signed [ACC_WIDTH:0] ext, sum, t;
      logic [DATA_WIDTH-1:0]     res;
      logic                      pos, neg;
      assign ext = {reduced_vec[i*ACC_WIDTH+ACC_WIDTH-1], reduced_vec[i*ACC_WIDTH +: ACC_WIDTH]};
      assign sum = ext + RND;
      assign t   = sum >>> FRAC_BITS;
      always_comb begin
         pos = (t > MAXV);
         neg = (t < MINV);
         res = t[DATA_WIDTH-1:0];
         if (pos)      res = MAXV[DATA_WIDTH-1:0];
         else if (neg) res = MINV[DATA_WIDTH-1:0];
`ifdef REQUANT_RELU_EN
         if (t[ACC_WIDTH]) res = '0;
`endif
      end
`ifdef REQUANT_RELU_EN
      assign sat_flag[i] = pos;
`else
      assign sat_flag[i] = pos | neg;
`endif
      assign req_vec[i*DATA_WIDTH +: DATA_WIDTH] = res;
   end

   always_comb begin
      q_vec_d   = q_vec_q;
      q_valid_d = q_valid_q;
      state_d   = state_q;
      slot_d    = slot_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      n_sat     = '0;
      sat_sum   = '0;
      for (int i = 0; i < TILE_SIZE; i++) n_sat = n_sat + 16'(sat_flag[i]);
      sat_cnt_d = start ? '0 : sat_cnt_q;
      if (q_adv) q_valid_d = 1'b0;
      if (accept) begin
         q_vec_d   = req_vec;
         q_valid_d = 1'b1;
         sat_sum   = {1'b0, sat_cnt_d} + {1'b0, n_sat};
         sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
      if (wr_hs) begin
         done_d    = (wr_addr_q == ADDR_W'(NUM_LINES-1));
         wr_addr_d = done_d ? '0 : wr_addr_q + 1'b1;
         state_d   = FILL;
      end
      // in HOLD slot_q is 0, so a write-out cycle can refill slot 0 in the same edge
      if (q_adv) begin
         wr_data_d[slot_q*VEC_W +: VEC_W] = q_vec_q;
         if (slot_q == SLOT_W'(PACK-1)) begin
            state_d = HOLD;
            slot_d  = '0;
         end else begin
            slot_d = slot_q + 1'b1;
         end
      end
      if (start) begin
         slot_d    = '0;
         wr_addr_d = '0;
         state_d   = FILL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_vec_q   <= '0;
         q_valid_q <= 1'b0;
         state_q   <= FILL;
         slot_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         sat_cnt_q <= '0;
      end else begin
         q_vec_q   <= q_vec_d;
         q_valid_q <= q_valid_d;
         state_q   <= state_d;
         slot_q    <= slot_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign wr_en   = (state_q == HOLD);
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign done    = done_q;
   assign sat_cnt = sat_cnt_q;
endmodule
